// File: rtl/bvh_trav_ctrl.sv
// bvh_trav_ctrl: per-ray BVH traversal FSM; descends into the nearer hit child and
// keeps farther hit children on a bounded LIFO, handing leaves to the primitive tester.
module bvh_trav_ctrl #(
    parameter int DEPTH = 32,
    parameter int IDX_W = 24,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [IDX_W-1:0] root_node,
    input  logic             abort,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [IDX_W-1:0] req_node,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic             res_leaf,
    input  logic [31:0]      res_tmin0,
    input  logic [31:0]      res_tmax0,
    input  logic [31:0]      res_tmin1,
    input  logic [31:0]      res_tmax1,
    input  logic [IDX_W-1:0] res_child0,
    input  logic [IDX_W-1:0] res_child1,
    output logic             leaf_valid,
    input  logic             leaf_ready,
    output logic [IDX_W-1:0] leaf_node,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] visited
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, LEAF, DONE} state_t;
    state_t           state_q, state_d;
    logic [IDX_W-1:0] cur_q, cur_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] vis_q, vis_d;
    logic [IDX_W-1:0] stk_q [DEPTH];
    logic [IDX_W-1:0] far;
    logic [AW-1:0]    top_idx;
    logic             push, full, do_pop, hit0, hit1, near1;
    // Maps IEEE-754 bit patterns onto unsigned integers with the same total order.
    function automatic logic [31:0] key(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction
    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction
    assign hit0    = !is_nan(res_tmin0) && !is_nan(res_tmax0) && (key(res_tmin0) <= key(res_tmax0));
    assign hit1    = !is_nan(res_tmin1) && !is_nan(res_tmax1) && (key(res_tmin1) <= key(res_tmax1));
    assign near1   = key(res_tmin1) < key(res_tmin0);
    assign full    = sp_q == SPW'(DEPTH);
    assign top_idx = AW'(sp_q - 1'b1);
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        vis_d   = vis_q;
        far     = res_child1;
        push    = 1'b0;
        do_pop  = 1'b0;
        if (state_q != IDLE && abort) begin
            state_d = IDLE;
            sp_d    = '0;
        end else begin
            case (state_q)
                IDLE: if (start_valid) begin
                    cur_d   = root_node;
                    sp_d    = '0;
                    ovf_d   = 1'b0;
                    vis_d   = '0;
                    state_d = REQ;
                end
                REQ: if (req_ready) begin
                    vis_d   = &vis_q ? vis_q : vis_q + 1'b1;
                    state_d = WAIT;
                end
                WAIT: if (res_valid) begin
                    if (res_leaf) begin
                        state_d = LEAF;
                    end else if (hit0 && hit1) begin
                        cur_d   = near1 ? res_child1 : res_child0;
                        far     = near1 ? res_child0 : res_child1;
                        push    = !full;
                        ovf_d   = ovf_q | full;
                        sp_d    = full ? sp_q : sp_q + 1'b1;
                        state_d = REQ;
                    end else if (hit0 || hit1) begin
                        cur_d   = hit0 ? res_child0 : res_child1;
                        state_d = REQ;
                    end else begin
                        do_pop = 1'b1;
                    end
                end
                LEAF: do_pop = leaf_ready;
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
            if (do_pop) begin
                state_d = (sp_q == '0) ? DONE : REQ;
                cur_d   = (sp_q == '0) ? cur_q : stk_q[top_idx];
                sp_d    = (sp_q == '0) ? sp_q : sp_q - 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            vis_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            vis_q   <= vis_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) stk_q[AW'(sp_q)] <= far;
    end
    assign start_ready = state_q == IDLE;
    assign req_valid   = state_q == REQ;
    assign res_ready   = state_q == WAIT;
    assign leaf_valid  = state_q == LEAF;
    assign done        = state_q == DONE;
    assign req_node    = cur_q;
    assign leaf_node   = cur_q;
    assign overflow    = ovf_q;
    assign visited     = vis_q;
endmodule

// File: tb/tb_bvh_trav_ctrl.sv
// tb_bvh_trav_ctrl: directed BVH trees driven through the controller; a reference
// traversal predicts the event stream that a per-cycle monitor checks.
module tb_bvh_trav_ctrl;
    localparam int DEPTH = 2;
    localparam int IDX_W = 24;
    localparam int CNT_W = 4;
    localparam int EV_REQ = 0, EV_LEAF = 1, EV_DONE = 2, EV_WAIT = 3;
    logic clk = 1'b0, reset = 1'b1;
    logic start_valid = 0, abort = 0, req_ready = 0, res_valid = 0, res_leaf = 0, leaf_ready = 0;
    logic [IDX_W-1:0] root_node = '0, res_child0 = '0, res_child1 = '0;
    logic [31:0] res_tmin0 = 0, res_tmax0 = 0, res_tmin1 = 0, res_tmax1 = 0;
    logic start_ready, req_valid, res_ready, leaf_valid, done, overflow;
    logic [IDX_W-1:0] req_node, leaf_node;
    logic [CNT_W-1:0] visited;
    typedef struct { bit leaf; logic [31:0] tn0, tx0, tn1, tx1; int c0, c1; } node_t;
    typedef struct { int kind; int node; } ev_t;
    node_t tbl [64];
    ev_t exp_q [$];
    int req_log [$];
    int exp_vis, leaf_cyc, nk = -1;
    bit exp_ovf, mon_en = 0;
    int checks = 0, failures = 0;
    bvh_trav_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
        .root_node(root_node), .abort(abort), .req_valid(req_valid), .req_ready(req_ready),
        .req_node(req_node), .res_valid(res_valid), .res_ready(res_ready), .res_leaf(res_leaf),
        .res_tmin0(res_tmin0), .res_tmax0(res_tmax0), .res_tmin1(res_tmin1), .res_tmax1(res_tmax1),
        .res_child0(res_child0), .res_child1(res_child1), .leaf_valid(leaf_valid),
        .leaf_ready(leaf_ready), .leaf_node(leaf_node), .done(done), .overflow(overflow),
        .visited(visited)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask
    function automatic real f2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'h00) return 0.0;
        d = {x[31], (x[30:23] == 8'hFF) ? 11'h7FF : 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction
    function automatic bit is_nan(input logic [31:0] x);
        return x[30:23] == 8'hFF && x[22:0] != 0;
    endfunction
    function automatic bit hit(input logic [31:0] tn, input logic [31:0] tx);
        return !is_nan(tn) && !is_nan(tx) && f2r(tn) <= f2r(tx);
    endfunction
    // Reference depth-first traversal producing the expected request/leaf/done sequence.
    function automatic void build_exp(input int root);
        int st [$];
        int cur, vis, far;
        bit ovf, pop, h0, h1, one_first;
        node_t n;
        real r0, r1;
        cur = root; vis = 0; ovf = 0;
        exp_q.delete();
        for (int g = 0; g < 200; g++) begin
            n = tbl[cur];
            exp_q.push_back('{EV_REQ, cur});
            vis = (vis == (1 << CNT_W) - 1) ? vis : vis + 1;
            pop = 0;
            if (n.leaf) begin
                exp_q.push_back('{EV_LEAF, cur});
                pop = 1;
            end else begin
                h0 = hit(n.tn0, n.tx0);
                h1 = hit(n.tn1, n.tx1);
                if (h0 && h1) begin
                    r0 = f2r(n.tn0);
                    r1 = f2r(n.tn1);
                    one_first = r1 < r0 || (r1 == r0 && n.tn1[31] && !n.tn0[31]);
                    far = one_first ? n.c0 : n.c1;
                    cur = one_first ? n.c1 : n.c0;
                    if (st.size() < DEPTH) st.push_back(far);
                    else ovf = 1;
                end else if (h0) cur = n.c0;
                else if (h1) cur = n.c1;
                else pop = 1;
            end
            if (pop) begin
                if (st.size() == 0) begin
                    exp_q.push_back('{EV_DONE, 0});
                    break;
                end
                cur = st.pop_back();
            end
        end
        exp_vis = vis;
        exp_ovf = ovf;
    endfunction
    always @(negedge clk) begin
        ev_t f;
        if (mon_en && !reset) begin
            if (nk == EV_REQ) chk("lat_req_valid", req_valid, 1);
            if (nk == EV_LEAF) chk("lat_leaf_valid", leaf_valid, 1);
            if (nk == EV_DONE) chk("lat_done", done, 1);
            if (nk == EV_WAIT) chk("lat_res_ready", res_ready, 1);
            nk = -1;
            f = '{-1, -1};
            if (exp_q.size() > 0) f = exp_q[0];
            if (req_valid) begin
                chk("req_event", f.kind, EV_REQ);
                chk("req_node", req_node, f.node);
                if (req_ready && !abort) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    nk = EV_WAIT;
                end
            end
            if (leaf_valid) begin
                chk("leaf_event", f.kind, EV_LEAF);
                chk("leaf_node", leaf_node, f.node);
                if (leaf_ready && !abort) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    nk = exp_q.size() > 0 ? exp_q[0].kind : -1;
                end
            end
            if (done) begin
                chk("done_event", f.kind, EV_DONE);
                chk("done_visited", visited, exp_vis);
                chk("done_overflow", overflow, exp_ovf);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (res_valid && res_ready && !abort) nk = exp_q.size() > 0 ? exp_q[0].kind : -1;
            if (start_valid && start_ready) nk = EV_REQ;
        end
    end
    task automatic set_int(input int i, input logic [31:0] tn0, input logic [31:0] tx0,
                           input logic [31:0] tn1, input logic [31:0] tx1, input int c0, input int c1);
        tbl[i] = '{1'b0, tn0, tx0, tn1, tx1, c0, c1};
    endtask
    task automatic run_ray(input int root, input int stall, input int abort_at);
        int last, sc;
        bit fin, ab;
        node_t n;
        last = 0; sc = 0; fin = 0; ab = 0; leaf_cyc = 0;
        build_exp(root);
        req_log.delete();
        @(posedge clk); #1;
        start_valid = 1;
        root_node = IDX_W'(root);
        @(posedge clk); #1;
        start_valid = 0;
        for (int c = 0; c < 300 && !fin; c++) begin
            if (done || (ab && start_ready)) begin
                fin = 1;
            end else begin
                req_ready = req_valid;
                if (req_valid) begin
                    last = int'(req_node);
                    req_log.push_back(last);
                end
                abort = res_ready && abort_at != 0 && req_log.size() == abort_at;
                if (abort) ab = 1;
                res_valid = res_ready || leaf_valid;
                n = res_ready ? tbl[last] : '{1'b0, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40000000, 63, 62};
                res_leaf = n.leaf;
                res_tmin0 = n.tn0; res_tmax0 = n.tx0; res_tmin1 = n.tn1; res_tmax1 = n.tx1;
                res_child0 = IDX_W'(n.c0); res_child1 = IDX_W'(n.c1);
                if (leaf_valid) begin
                    sc++;
                    leaf_cyc++;
                    leaf_ready = sc > stall;
                end else begin
                    sc = 0;
                    leaf_ready = 0;
                end
                @(posedge clk); #1;
            end
        end
        chk("ray_finished", fin, 1);
        {req_ready, res_valid, leaf_ready, abort} = '0;
        if (ab) exp_q.delete();
        @(negedge clk); #1;
        if (!ab) chk("exp_drained", exp_q.size(), 0);
    endtask
    initial begin
        for (int i = 0; i < 64; i++) tbl[i] = '{1'b1, 0, 0, 0, 0, 0, 0};
        set_int(1, 32'h40400000, 32'h40000000, 32'h7FC00000, 32'h40400000, 60, 61);
        set_int(2, 32'h40000000, 32'h40400000, 32'h3F800000, 32'h40400000, 3, 4);
        set_int(10, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h40400000, 11, 20);
        set_int(11, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h40400000, 12, 21);
        set_int(12, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h40400000, 13, 22);
        set_int(30, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40000000, 31, 32);
        set_int(33, 32'h80000000, 32'h00000000, 32'h40000000, 32'h3F800000, 34, 59);
        set_int(35, 32'h00000000, 32'h3F800000, 32'h80000000, 32'h3F800000, 36, 37);
        for (int i = 40; i < 56; i++) set_int(i, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40000000, i + 1, 58);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_ready", start_ready, 1);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_res_ready", res_ready, 0);
        chk("rst_leaf_valid", leaf_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_visited", visited, 0);
        chk("rst_req_node", req_node, 0);
        reset = 0;
        mon_en = 1;
        run_ray(1, 0, 0);
        chk("miss_reqs", req_log.size(), 1);
        chk("miss_visited", visited, 1);
        chk("miss_overflow", overflow, 0);
        run_ray(2, 0, 0);
        chk("near_first_req", req_log[1], 4);
        chk("popped_req", req_log[2], 3);
        chk("near_visited", visited, 3);
        run_ray(5, 5, 0);
        chk("stall_leaf_cycles", leaf_cyc, 6);
        chk("stall_reqs", req_log.size(), 1);
        run_ray(10, 0, 0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_visited", visited, 6);
        chk("ovf_pop_order", req_log[4], 21);
        run_ray(10, 0, 4);
        chk("abort_start_ready", start_ready, 1);
        chk("abort_overflow_held", overflow, 1);
        chk("abort_visited_held", visited, 4);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_done", done, 0);
            chk("abort_idle_req", req_valid, 0);
            @(posedge clk); #1;
        end
        run_ray(1, 0, 0);
        chk("restart_overflow", overflow, 0);
        chk("restart_visited", visited, 1);
        run_ray(30, 0, 0);
        chk("tie_child0", req_log[1], 31);
        run_ray(33, 0, 0);
        chk("negzero_hit", req_log[1], 34);
        chk("negzero_visited", visited, 2);
        run_ray(35, 0, 0);
        chk("negzero_nearer", req_log[1], 37);
        run_ray(40, 0, 0);
        chk("sat_reqs", req_log.size(), 17);
        chk("sat_visited", visited, 15);
        mon_en = 0;
        @(posedge clk); #1;
        start_valid = 1; root_node = 24'd10;
        @(posedge clk); #1;
        start_valid = 0; req_ready = 1;
        @(posedge clk); #1;
        req_ready = 0;
        chk("pre_rst_visited", visited, 1);
        chk("pre_rst_res_ready", res_ready, 1);
        #2 reset = 1;
        #1;
        chk("mid_rst_start_ready", start_ready, 1);
        chk("mid_rst_res_ready", res_ready, 0);
        chk("mid_rst_visited", visited, 0);
        chk("mid_rst_req_node", req_node, 0);
        chk("mid_rst_leaf_node", leaf_node, 0);
        @(posedge clk); #1;
        reset = 0;
        nk = -1;
        mon_en = 1;
        run_ray(2, 1, 0);
        chk("post_rst_visited", visited, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
